sobel_window_buffer: RTL and testbench
======================================

// Module: sobel_window_buffer
// PURPOSE
//  Upstream neighbour of the Sobel compute stage. Accepts a raster-order pixel stream for one
//  frame of programmable width x length. Keeps the two previous image rows in line buffers and
//  emits every complete 3x3 neighbourhood, one per handshake, to the gradient/magnitude stage.
//  Border pixels produce no window. The output count is (width-2)*(length-2) per frame.
// PARAMETERS
//  PIXEL_W    8    bits per pixel
//  MAX_WIDTH  640  maximum row length; sets line-buffer depth
// PORTS
//  clk           in   1          system clock, all logic on rising edge
//  n_rst         in   1          reset, synchronous, active-low
//  start         in   1          1-cycle pulse; latches width/length and begins a frame (IDLE only)
//  width         in   12         pixels per row, sampled on accepted start
//  length        in   12         rows per frame, sampled on accepted start
//  pix_in        in   PIXEL_W    input pixel, raster order
//  pix_in_valid  in   1          pix_in holds a valid pixel
//  pix_in_ready  out  1          block accepts pix_in this cycle
//  win_out       out  9*PIXEL_W  window, row-major: [9*PW-1 -: PW]=top-left ... [PW-1:0]=bottom-right
//  win_valid     out  1          win_out valid; held with win_out stable until win_ready
//  win_ready     in   1          downstream consumes window when win_valid&&win_ready
//  busy          out  1          high from the cycle after accepted start until the cycle of frame_done
//  frame_done    out  1          1-cycle pulse at end of frame
// BEHAVIOUR
//  Reset (n_rst=0 at a rising edge):
//   - state=IDLE; counters cleared.
//   - pix_in_ready, win_valid, busy and frame_done are 0; win_out is 0.
//   - Line-buffer contents are don't-care and are not cleared.
//  FSM states IDLE -> STREAM -> DRAIN -> IDLE.
//   - IDLE: pix_in_ready=0. On start with 3<=width<=MAX_WIDTH and 3<=length, latch dims,
//     clear col/row, go to STREAM.
//   - IDLE, start with illegal dims: stay IDLE, pulse frame_done next cycle, produce no windows.
//   - start outside IDLE is ignored.
//   - STREAM: pix_in_ready = !win_valid || win_ready (one-deep output, full-throughput when
//     downstream is ready). A pixel is accepted when pix_in_valid&&pix_in_ready.
//   - On the accept of pixel (row=length-1, col=width-1), go to DRAIN.
//   - DRAIN: pix_in_ready=0. When no window is pending (win_valid=0, or its handshake completes
//     this cycle), pulse frame_done for one cycle, drop busy, go to IDLE.
//  Datapath, per accepted pixel at (row,col):
//   - top=lb1[col], mid=lb0[col], bot=pix_in.
//   - Line-buffer update: lb1[col]<=lb0[col]; lb0[col]<=pix_in.
//   - Each of the 3 rows shifts into a 3-deep column shift register; the newest column is right.
//   - col increments. At col==width-1 it wraps to 0 and row increments.
//   - If row>=2 and col>=2, win_valid<=1 at the same edge and win_out<=the new 3x3 contents.
//     Latency: window visible the cycle after the accepting edge.
//   - Window registers are loaded only on accept, so win_out never changes while win_valid&&!win_ready.
//   - Windows never span a row wrap: col<2 columns are loaded into the shift registers but not emitted.
//  Simultaneous events: a window handshake and a new pixel accept in the same cycle are legal;
//   win_valid stays 1 with the new window.
//  Counters are 12-bit unsigned; no arithmetic overflow is possible given the legal dims.
//  Reset mid-frame aborts immediately. No frame_done is issued for the aborted frame. The next
//   start begins a clean frame.
// TESTING
//  1 4x4 frame, pix=row*4+col, win_ready=1 -> exactly 4 windows.
//    First window = {0,1,2,4,5,6,8,9,10}; last = {5,6,7,9,10,11,13,14,15}.
//    frame_done pulses once, in the cycle after the last window handshake.
//  2 Same frame, win_ready=0 for 5 cycles while win_valid=1 -> win_out stable, pix_in_ready=0;
//    after release, all 4 windows arrive in order, none lost or duplicated.
//  3 start with width=2, length=5 -> frame_done pulse the next cycle; win_valid, busy and
//    pix_in_ready stay 0.
//  4 5x5 frame, n_rst=0 after 7 accepted pixels -> next cycle all outputs 0 and no frame_done;
//    then a 3x3 frame of 1..9 -> exactly 1 window {1..9}.
//  5 width=640, length=3, random pixels, pix_in_valid randomly toggled -> 638 windows matching
//    the reference model, each column triple correct across row wraps.
//  6 start pulsed during STREAM with different dims -> ignored; the current frame completes with
//    the original window count.

Source files
------------

// File: rtl/sobel_window_buffer_if.sv
// Stream-side bundle for the Sobel window buffer: frame control, pixel input
// handshake and 3x3 window output handshake.
interface sobel_window_buffer_if #(
   parameter int PIXEL_W = 8
);
   logic                   start;
   logic [11:0]            width;
   logic [11:0]            length;
   logic [PIXEL_W-1:0]     pix_in;
   logic                   pix_in_valid;
   logic                   pix_in_ready;
   logic [9*PIXEL_W-1:0]   win_out;
   logic                   win_valid;
   logic                   win_ready;
   logic                   busy;
   logic                   frame_done;

   modport master (
      output start, width, length, pix_in, pix_in_valid, win_ready,
      input  pix_in_ready, win_out, win_valid, busy, frame_done
   );

   modport slave (
      input  start, width, length, pix_in, pix_in_valid, win_ready,
      output pix_in_ready, win_out, win_valid, busy, frame_done
   );
endinterface

// File: rtl/sobel_window_buffer.sv
// Raster-order pixel stream to 3x3 neighbourhood converter. Two line buffers hold
// the previous rows; one window is emitted per interior pixel through a one-deep output stage.
module sobel_window_buffer #(
   parameter int PIXEL_W   = 8,
   parameter int MAX_WIDTH = 640
) (
   input  logic                 clk,
   input  logic                 n_rst,
   sobel_window_buffer_if.slave bus
);
   localparam int          ADDR_W  = $clog2(MAX_WIDTH);
   localparam logic [11:0] MAX_W_C = 12'(MAX_WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2
   } state_t;

   state_t                 state_r;
   state_t                 state_nxt_s;
   logic                   frame_done_r;
   logic                   frame_done_nxt_s;
   logic                   busy_r;

   logic [11:0]            width_r;
   logic [11:0]            length_r;
   logic [11:0]            col_r;
   logic [11:0]            row_r;

   logic [PIXEL_W-1:0]     lb0_r [0:MAX_WIDTH-1];
   logic [PIXEL_W-1:0]     lb1_r [0:MAX_WIDTH-1];

   // Older columns of the 3-row shift register, each packed {top, mid, bot}.
   logic [3*PIXEL_W-1:0]   col_l_r;
   logic [3*PIXEL_W-1:0]   col_c_r;

   logic [9*PIXEL_W-1:0]   win_out_r;
   logic                   win_valid_r;

   logic [ADDR_W-1:0]      col_addr_s;
   logic [PIXEL_W-1:0]     top_s;
   logic [PIXEL_W-1:0]     mid_s;
   logic [PIXEL_W-1:0]     bot_s;
   logic [9*PIXEL_W-1:0]   win_s;
   logic                   dims_ok_s;
   logic                   start_ok_s;
   logic                   pix_in_ready_s;
   logic                   accept_s;
   logic                   emit_s;
   logic                   last_pix_s;
   logic                   col_wrap_s;

   assign dims_ok_s      = (bus.width >= 12'd3) && (bus.width <= MAX_W_C) && (bus.length >= 12'd3);
   assign start_ok_s     = (state_r == ST_IDLE) && bus.start && dims_ok_s;
   assign pix_in_ready_s = (state_r == ST_STREAM) && (!win_valid_r || bus.win_ready);
   assign accept_s       = bus.pix_in_valid && pix_in_ready_s;
   assign col_wrap_s     = (col_r == (width_r - 12'd1));
   assign last_pix_s     = (row_r == (length_r - 12'd1)) && col_wrap_s;
   assign emit_s         = accept_s && (row_r >= 12'd2) && (col_r >= 12'd2);

   assign col_addr_s = col_r[ADDR_W-1:0];
   assign top_s      = lb1_r[col_addr_s];
   assign mid_s      = lb0_r[col_addr_s];
   assign bot_s      = bus.pix_in;

   assign win_s = {col_l_r[3*PIXEL_W-1 -: PIXEL_W], col_c_r[3*PIXEL_W-1 -: PIXEL_W], top_s,
                   col_l_r[2*PIXEL_W-1 -: PIXEL_W], col_c_r[2*PIXEL_W-1 -: PIXEL_W], mid_s,
                   col_l_r[PIXEL_W-1:0],            col_c_r[PIXEL_W-1:0],            bot_s};

   // Frame sequencing: next state and end-of-frame pulse.
   always_comb begin
      state_nxt_s      = state_r;
      frame_done_nxt_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               if (dims_ok_s) begin
                  state_nxt_s = ST_STREAM;
               end else begin
                  frame_done_nxt_s = 1'b1;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_STREAM: begin
            if (accept_s && last_pix_s) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_STREAM;
            end
         end
         ST_DRAIN: begin
            if (!win_valid_r || bus.win_ready) begin
               state_nxt_s      = ST_IDLE;
               frame_done_nxt_s = 1'b1;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register with registered busy and frame_done.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_r      <= ST_IDLE;
         frame_done_r <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         frame_done_r <= frame_done_nxt_s;
         busy_r       <= (state_nxt_s != ST_IDLE);
      end
   end

   // Frame dimensions and raster position.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         width_r  <= 12'd0;
         length_r <= 12'd0;
         col_r    <= 12'd0;
         row_r    <= 12'd0;
      end else if (start_ok_s) begin
         width_r  <= bus.width;
         length_r <= bus.length;
         col_r    <= 12'd0;
         row_r    <= 12'd0;
      end else if (accept_s) begin
         if (col_wrap_s) begin
            col_r <= 12'd0;
            row_r <= row_r + 12'd1;
         end else begin
            col_r <= col_r + 12'd1;
         end
      end
   end

   // Line buffers are storage only; their contents need no reset.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         lb1_r[col_addr_s] <= lb0_r[col_addr_s];
         lb0_r[col_addr_s] <= bus.pix_in;
      end
   end

   // Column shift register and one-deep window output stage.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         col_l_r     <= '0;
         col_c_r     <= '0;
         win_out_r   <= '0;
         win_valid_r <= 1'b0;
      end else begin
         if (accept_s) begin
            col_l_r <= col_c_r;
            col_c_r <= {top_s, mid_s, bot_s};
         end
         // A window is loaded only on an accept, so a stalled window never changes.
         if (emit_s) begin
            win_valid_r <= 1'b1;
            win_out_r   <= win_s;
         end else if (win_valid_r && bus.win_ready) begin
            win_valid_r <= 1'b0;
         end
      end
   end

   assign bus.pix_in_ready = pix_in_ready_s;
   assign bus.win_out      = win_out_r;
   assign bus.win_valid    = win_valid_r;
   assign bus.busy         = busy_r;
   assign bus.frame_done   = frame_done_r;
endmodule

// File: tb/tb_sobel_window_buffer.sv
// Self-checking bench for sobel_window_buffer: an image-level model builds the
// expected window list; a negedge monitor checks every window handshake against it.
module tb_sobel_window_buffer;
   localparam int PW   = 8;
   localparam int MAXW = 640;

   logic tb_clk = 1'b0;
   logic n_rst;
   always #5 tb_clk = ~tb_clk;

   sobel_window_buffer_if #(.PIXEL_W(PW)) bus();

   sobel_window_buffer #(.PIXEL_W(PW), .MAX_WIDTH(MAXW)) dut (
      .clk   (tb_clk),
      .n_rst (n_rst),
      .bus   (bus.slave)
   );

   int           checks   = 0;
   int           failures = 0;
   int           cyc      = 0;
   int           win_cnt  = 0;
   int           fd_cnt   = 0;
   int           fd_cyc   = 0;
   int           last_hs_cyc = 0;
   logic [71:0]  first_win;
   logic [71:0]  last_win;
   logic [71:0]  exp_q[$];
   logic [7:0]   img [0:2047];
   bit           stall_req = 1'b0;
   int           stall_cnt = 0;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference: every interior 3x3 neighbourhood of the image, raster order, row-major packing.
   task automatic build_expected(input int w, input int l);
      logic [71:0] wv;
      exp_q.delete();
      for (int r = 2; r < l; r++) begin
         for (int c = 2; c < w; c++) begin
            wv = '0;
            for (int dr = 0; dr < 3; dr++)
               for (int dc = 0; dc < 3; dc++)
                  wv = {wv[63:0], img[(r - 2 + dr) * w + (c - 2 + dc)]};
            exp_q.push_back(wv);
         end
      end
   endtask

   initial forever begin
      @(posedge tb_clk);
      cyc++;
   end

   // Monitor: stability during stall, window data at each handshake, frame_done pulses.
   initial begin
      logic [71:0] prev_win;
      logic [71:0] exp_w;
      bit          hold_prev;
      hold_prev = 1'b0;
      prev_win  = '0;
      forever begin
         @(negedge tb_clk);
         if (n_rst === 1'b1) begin
            if (hold_prev && bus.win_valid)
               chk("win_stable", bus.win_out, prev_win);
            if (bus.win_valid && !bus.win_ready)
               chk("ready_low_in_stall", 72'(bus.pix_in_ready), 72'd0);
            if (bus.win_valid && bus.win_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_window actual=%h required=none", bus.win_out);
               end else begin
                  exp_w = exp_q.pop_front();
                  chk("win_data", bus.win_out, exp_w);
               end
               if (win_cnt == 0) first_win = bus.win_out;
               last_win    = bus.win_out;
               last_hs_cyc = cyc;
               win_cnt++;
            end
            hold_prev = bus.win_valid && !bus.win_ready;
            prev_win  = bus.win_out;
            if (bus.frame_done) begin
               fd_cnt++;
               fd_cyc = cyc;
            end
         end else begin
            hold_prev = 1'b0;
         end
      end
   end

   task automatic step(output bit acc);
      if (stall_req && bus.win_valid && stall_cnt < 5) begin
         bus.win_ready = 1'b0;
         stall_cnt++;
      end else begin
         bus.win_ready = 1'b1;
      end
      @(negedge tb_clk);
      acc = bus.pix_in_valid && bus.pix_in_ready;
      @(posedge tb_clk);
      #1;
   endtask

   task automatic do_start(input int w, input int l);
      bus.start  = 1'b1;
      bus.width  = 12'(w);
      bus.length = 12'(l);
      @(posedge tb_clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic stream(input int npix, input bit rand_valid, input int restart_at);
      int idx   = 0;
      int guard = 0;
      bit acc;
      bit restarted = 1'b0;
      while (idx < npix && guard < 20000) begin
         bus.pix_in       = img[idx];
         bus.pix_in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
         if (idx == restart_at && !restarted) begin
            bus.start  = 1'b1;
            bus.width  = 12'd3;
            bus.length = 12'd3;
            restarted  = 1'b1;
         end
         step(acc);
         bus.start = 1'b0;
         if (acc) idx++;
         guard++;
      end
      bus.pix_in_valid = 1'b0;
      if (idx < npix) begin
         checks++;
         failures++;
         $display("FAIL stream_timeout accepted=%0d required=%0d", idx, npix);
      end
   endtask

   task automatic wait_done(input int budget);
      int fd0 = fd_cnt;
      int n   = 0;
      bit a;
      while (fd_cnt == fd0 && n < budget) begin
         step(a);
         n++;
      end
      if (fd_cnt == fd0) begin
         checks++;
         failures++;
         $display("FAIL frame_done_timeout waited=%0d required=pulse", n);
      end
   endtask

   task automatic run_frame(input int w, input int l, input bit rand_valid, input int restart_at);
      int fd0;
      bit a;
      build_expected(w, l);
      win_cnt = 0;
      fd0     = fd_cnt;
      do_start(w, l);
      chk("busy_after_start", 72'(bus.busy), 72'd1);
      stream(w * l, rand_valid, restart_at);
      wait_done(200);
      repeat (3) step(a);
      chk("model_drained", 72'(exp_q.size()), 72'd0);
      chk("frame_done_once", 72'(fd_cnt - fd0), 72'd1);
      chk("busy_after_frame", 72'(bus.busy), 72'd0);
   endtask

   initial begin
      bit a;
      int fd0;
      int win0;
      n_rst            = 1'b0;
      bus.start        = 1'b0;
      bus.width        = 12'd0;
      bus.length       = 12'd0;
      bus.pix_in       = 8'd0;
      bus.pix_in_valid = 1'b0;
      bus.win_ready    = 1'b1;
      repeat (2) @(posedge tb_clk);
      @(negedge tb_clk);
      chk("rst_pix_in_ready", 72'(bus.pix_in_ready), 72'd0);
      chk("rst_win_valid",    72'(bus.win_valid),    72'd0);
      chk("rst_busy",         72'(bus.busy),         72'd0);
      chk("rst_frame_done",   72'(bus.frame_done),   72'd0);
      chk("rst_win_out",      bus.win_out,           72'd0);
      n_rst = 1'b1;
      @(posedge tb_clk);
      #1;

      // 4x4 ramp, downstream always ready
      for (int i = 0; i < 16; i++) img[i] = 8'(i);
      build_expected(4, 4);
      chk("model_first_4x4", exp_q[0], 72'h00_01_02_04_05_06_08_09_0A);
      chk("model_last_4x4",  exp_q[3], 72'h05_06_07_09_0A_0B_0D_0E_0F);
      run_frame(4, 4, 1'b0, -1);
      chk("t1_win_count", 72'(win_cnt), 72'd4);
      chk("t1_first_win", first_win, 72'h00_01_02_04_05_06_08_09_0A);
      chk("t1_last_win",  last_win,  72'h05_06_07_09_0A_0B_0D_0E_0F);
      chk("t1_done_timing", 72'(fd_cyc), 72'(last_hs_cyc + 1));

      // Same frame with a 5-cycle downstream stall
      stall_req = 1'b1;
      stall_cnt = 0;
      run_frame(4, 4, 1'b0, -1);
      stall_req = 1'b0;
      chk("t2_stall_cycles", 72'(stall_cnt), 72'd5);
      chk("t2_win_count", 72'(win_cnt), 72'd4);
      chk("t2_last_win",  last_win, 72'h05_06_07_09_0A_0B_0D_0E_0F);

      // Illegal dimensions: immediate frame_done, nothing else
      win0 = win_cnt;
      do_start(2, 5);
      @(negedge tb_clk);
      chk("t3_frame_done",   72'(bus.frame_done),   72'd1);
      chk("t3_busy",         72'(bus.busy),         72'd0);
      chk("t3_win_valid",    72'(bus.win_valid),    72'd0);
      chk("t3_pix_in_ready", 72'(bus.pix_in_ready), 72'd0);
      @(posedge tb_clk);
      #1;
      do_start(700, 3);
      @(negedge tb_clk);
      chk("t3_wide_done",  72'(bus.frame_done), 72'd1);
      @(posedge tb_clk);
      #1;
      @(negedge tb_clk);
      chk("t3_done_pulse", 72'(bus.frame_done), 72'd0);
      chk("t3_no_windows", 72'(win_cnt), 72'(win0));
      @(posedge tb_clk);
      #1;

      // Reset mid-frame after 7 pixels, then a clean 3x3 frame
      for (int i = 0; i < 25; i++) img[i] = 8'(8'd100 + 8'(i));
      build_expected(5, 5);
      do_start(5, 5);
      stream(7, 1'b0, -1);
      n_rst = 1'b0;
      @(posedge tb_clk);
      #1;
      @(negedge tb_clk);
      chk("t4_pix_in_ready", 72'(bus.pix_in_ready), 72'd0);
      chk("t4_win_valid",    72'(bus.win_valid),    72'd0);
      chk("t4_busy",         72'(bus.busy),         72'd0);
      chk("t4_frame_done",   72'(bus.frame_done),   72'd0);
      chk("t4_win_out",      bus.win_out,           72'd0);
      n_rst = 1'b1;
      @(posedge tb_clk);
      #1;
      exp_q.delete();
      fd0 = fd_cnt;
      repeat (10) step(a);
      chk("t4_no_done_after_abort", 72'(fd_cnt), 72'(fd0));
      for (int i = 0; i < 9; i++) img[i] = 8'(i + 1);
      build_expected(3, 3);
      chk("model_3x3", exp_q[0], 72'h01_02_03_04_05_06_07_08_09);
      run_frame(3, 3, 1'b0, -1);
      chk("t4_win_count", 72'(win_cnt), 72'd1);
      chk("t4_win",       last_win, 72'h01_02_03_04_05_06_07_08_09);

      // Full-width 640x3, random pixels, random input valid
      for (int i = 0; i < 640 * 3; i++) img[i] = 8'($urandom_range(0, 255));
      run_frame(640, 3, 1'b1, -1);
      chk("t5_win_count", 72'(win_cnt), 72'd638);

      // start during STREAM with other dims must be ignored
      for (int i = 0; i < 16; i++) img[i] = 8'(i);
      run_frame(4, 4, 1'b0, 5);
      chk("t6_win_count", 72'(win_cnt), 72'd4);
      chk("t6_first_win", first_win, 72'h00_01_02_04_05_06_08_09_0A);
      chk("t6_last_win",  last_win,  72'h05_06_07_09_0A_0B_0D_0E_0F);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
